// File: rtl/tsc_trigger_sequencer.sv
// Armable trigger sequencer: counts AES completion pulses and opens a fixed trigger window at a threshold.
// Optional macro TSC_AUTO_REARM_EN: re-arm (or drop to IDLE) after the window instead of parking.
module tsc_trigger_sequencer #(
    parameter int               CNT_W      = 8,
    parameter logic [CNT_W-1:0] THRESH_RST = CNT_W'(16),
    parameter int               WIN_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             aes_done,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             cfg_rej,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             trigger
);

    localparam int WIN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        PARK  = 2'd3
    } state_t;

    state_t           cur_state, state_n;
    logic [CNT_W-1:0] thresh_q, thresh_n;
    logic [CNT_W-1:0] count_n, count_inc, eff_thresh;
    logic [WIN_W-1:0] win_q, win_n;
    logic             trigger_n, cfg_rej_n;

    assign state      = cur_state;
    assign count_inc  = count + CNT_W'(1);
    // A programmed threshold of zero behaves as one.
    assign eff_thresh = (thresh_q == '0) ? CNT_W'(1) : thresh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            count     <= '0;
            thresh_q  <= THRESH_RST;
            win_q     <= '0;
            trigger   <= 1'b0;
            cfg_rej   <= 1'b0;
        end else begin
            cur_state <= state_n;
            count     <= count_n;
            thresh_q  <= thresh_n;
            win_q     <= win_n;
            trigger   <= trigger_n;
            cfg_rej   <= cfg_rej_n;
        end
    end

    always_comb begin
        state_n  = cur_state;
        count_n  = count;
        thresh_n = thresh_q;
        win_n    = win_q;
        case (cur_state)
            IDLE: begin
                if (cfg_we)
                    thresh_n = cfg_thresh;
                if (arm) begin
                    state_n = ARMED;
                    count_n = '0;
                end
            end
            ARMED: begin
                // Disarm wins over a coincident completion pulse.
                if (!arm) begin
                    state_n = IDLE;
                    count_n = '0;
                end else if (aes_done) begin
                    count_n = count_inc;
                    if (count_inc == eff_thresh) begin
                        state_n = FIRE;
                        win_n   = WIN_W'(WIN_LEN);
                    end
                end
            end
            FIRE: begin
                win_n = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
`ifdef TSC_AUTO_REARM_EN
                    count_n = '0;
                    state_n = arm ? ARMED : IDLE;
`else
                    state_n = PARK;
`endif
                end
            end
            PARK: begin
                if (!arm) begin
                    state_n = IDLE;
                    count_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        trigger_n = (state_n == FIRE);
        cfg_rej_n = cfg_we && (cur_state != IDLE);
    end

endmodule

// File: tb/tb_tsc_trigger_sequencer.sv
// Directed bench for tsc_trigger_sequencer: a cycle table plus hand-written multi-cycle sequences.
module tb_tsc_trigger_sequencer;

`ifdef TSC_AUTO_REARM_EN
    localparam bit REARM = 1'b1;
`else
    localparam bit REARM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, arm, aes_done, cfg_we, cfg_rej, trigger;
    logic [7:0] cfg_thresh, count;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tsc_trigger_sequencer #(
        .CNT_W(8), .THRESH_RST(8'd16), .WIN_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .aes_done(aes_done),
        .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .cfg_rej(cfg_rej),
        .state(state), .count(count), .trigger(trigger)
    );

    typedef struct {
        logic       rst, arm, aes, we;
        logic [7:0] th;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       trg, rej;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, a, d, w, input logic [7:0] t,
                       input logic [1:0] s, input logic [7:0] c, input logic g, j);
        vec_t v;
        v.rst = r; v.arm = a; v.aes = d; v.we = w; v.th = t;
        v.st = s; v.cnt = c; v.trg = g; v.rej = j;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample 1ns after the next rising edge.
    task automatic step(input logic r, a, d, w, input logic [7:0] t);
        @(negedge clk);
        rst = r; arm = a; aes_done = d; cfg_we = w; cfg_thresh = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] s, input logic [7:0] c,
                             input logic g, input logic j);
        check({tag, ".state"}, state, s);
        check({tag, ".count"}, count, c);
        check({tag, ".trigger"}, trigger, g);
        check({tag, ".cfg_rej"}, cfg_rej, j);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; aes_done = 1'b0; cfg_we = 1'b0; cfg_thresh = 8'd0;

        //   rst  arm  aes  we  th      st     cnt   trg  rej
        add(1, 0, 0, 0, 8'd0,  2'd0, 8'd0, 0, 0);            // reset state
        add(0, 0, 1, 1, 8'd3,  2'd0, 8'd0, 0, 0);            // thresh=3, aes ignored in IDLE
        add(0, 1, 1, 0, 8'd0,  2'd1, 8'd0, 0, 0);            // arm rising, pulse not counted
        add(0, 1, 1, 0, 8'd0,  2'd1, 8'd1, 0, 0);
        add(0, 1, 0, 1, 8'd9,  2'd1, 8'd1, 0, 1);            // write in ARMED rejected
        add(0, 1, 0, 0, 8'd0,  2'd1, 8'd1, 0, 0);
        add(0, 1, 1, 0, 8'd0,  2'd1, 8'd2, 0, 0);
        add(0, 1, 1, 0, 8'd0,  2'd2, 8'd3, 1, 0);            // fires at 3, not 9
        add(0, 0, 1, 0, 8'd0,  2'd2, 8'd3, 1, 0);            // disarm does not cut window
        add(0, 0, 0, 0, 8'd0,  2'd2, 8'd3, 1, 0);
        add(0, 0, 0, 0, 8'd0,  2'd2, 8'd3, 1, 0);
        add(0, 0, 0, 0, 8'd0,  REARM ? 2'd0 : 2'd3, REARM ? 8'd0 : 8'd3, 0, 0);
        add(0, 0, 0, 0, 8'd0,  2'd0, 8'd0, 0, 0);
        add(0, 1, 0, 0, 8'd0,  2'd1, 8'd0, 0, 0);
        add(0, 1, 1, 0, 8'd0,  2'd1, 8'd1, 0, 0);
        add(0, 1, 1, 0, 8'd0,  2'd1, 8'd2, 0, 0);
        add(0, 0, 1, 0, 8'd0,  2'd0, 8'd0, 0, 0);            // disarm beats final pulse
        add(0, 0, 0, 0, 8'd0,  2'd0, 8'd0, 0, 0);
        add(0, 0, 0, 1, 8'd0,  2'd0, 8'd0, 0, 0);            // thresh=0 -> acts as 1
        add(0, 1, 0, 0, 8'd0,  2'd1, 8'd0, 0, 0);
        add(0, 1, 1, 0, 8'd0,  2'd2, 8'd1, 1, 0);
        add(0, 1, 0, 0, 8'd0,  2'd2, 8'd1, 1, 0);
        add(0, 1, 0, 0, 8'd0,  2'd2, 8'd1, 1, 0);
        add(0, 1, 0, 0, 8'd0,  2'd2, 8'd1, 1, 0);
        add(0, 1, 0, 0, 8'd0,  REARM ? 2'd1 : 2'd3, REARM ? 8'd0 : 8'd1, 0, 0);
        add(0, 0, 0, 0, 8'd0,  2'd0, 8'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].arm, vecs[i].aes, vecs[i].we, vecs[i].th);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].trg, vecs[i].rej);
        end

        // Default threshold 16, pulses spaced 3 cycles.
        step(1, 0, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0);
        check_all("seqA.arm", 2'd1, 8'd0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 1, 0, 8'd0);
            check_all($sformatf("seqA.pulse%0d", i), (i < 16) ? 2'd1 : 2'd2, 8'(i), i == 16, 0);
            if (i < 16) begin
                step(0, 1, 0, 0, 8'd0);
                step(0, 1, 0, 0, 8'd0);
            end
        end
        for (int k = 2; k <= 4; k++) begin
            step(0, 1, 0, 0, 8'd0);
            check_all($sformatf("seqA.win%0d", k), 2'd2, 8'd16, 1, 0);
        end
        step(0, 1, 0, 0, 8'd0);
        check_all("seqA.exit", REARM ? 2'd1 : 2'd3, REARM ? 8'd0 : 8'd16, 0, 0);

`ifndef TSC_AUTO_REARM_EN
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 0, 8'd0);
            check_all($sformatf("seqB.park%0d", i), 2'd3, 8'd16, 0, 0);
            step(0, 1, 0, 0, 8'd0);
        end
        step(0, 0, 0, 0, 8'd0);
        check_all("seqB.disarm", 2'd0, 8'd0, 0, 0);
        step(0, 1, 0, 0, 8'd0);
        check_all("seqB.rearm", 2'd1, 8'd0, 0, 0);
`endif

        // Reset in the second cycle of a window restores the default threshold.
        step(1, 0, 0, 0, 8'd0);
        step(0, 0, 0, 1, 8'd2);
        step(0, 1, 0, 0, 8'd0);
        step(0, 1, 1, 0, 8'd0);
        step(0, 1, 1, 0, 8'd0);
        check_all("seqC.fire", 2'd2, 8'd2, 1, 0);
        step(0, 1, 0, 0, 8'd0);
        check_all("seqC.win2", 2'd2, 8'd2, 1, 0);
        step(1, 1, 0, 0, 8'd0);
        check_all("seqC.rst", 2'd0, 8'd0, 0, 0);
        step(0, 1, 0, 0, 8'd0);
        for (int i = 1; i <= 15; i++) step(0, 1, 1, 0, 8'd0);
        check_all("seqC.cnt15", 2'd1, 8'd15, 0, 0);
        step(0, 1, 1, 0, 8'd0);
        check_all("seqC.cnt16", 2'd2, 8'd16, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tsc_trigger_sequencer.md
# tsc_trigger_sequencer

Sequencer for the trigger path of the AES core.
- Counts completed-encryption pulses from the AES core while armed.
- When the count reaches a programmable threshold, asserts a registered `trigger` for a fixed-length window.
- Then either parks or re-arms.
- Sits between the AES core's completion strobe and the payload logic, replacing a free-running trigger counter with a configurable, armable one.

## Interface
Parameters:
- `CNT_W`, 8: width of event counter and threshold.
- `THRESH_RST`, 8'd16: threshold value loaded at reset.
- `WIN_LEN`, 4: trigger window length in cycles, 1..15.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: level; high = arm / stay armed, low = disarm.
- `aes_done` in 1: one-cycle pulse per completed AES block.
- `cfg_we` in 1: threshold write strobe.
- `cfg_thresh` in `CNT_W`: threshold value written on `cfg_we`.
- `cfg_rej` out 1: one-cycle pulse; write was ignored (not IDLE).
- `state` out 2: current FSM state encoding.
- `count` out `CNT_W`: current event count.
- `trigger` out 1: registered trigger window.

## Operation
- States:
  - IDLE = 2'd0
  - ARMED = 2'd1
  - FIRE = 2'd2
  - PARK = 2'd3
- Reset values:
  - `state` IDLE
  - `count` 0
  - `trigger` 0
  - `cfg_rej` 0
  - internal threshold = `THRESH_RST`
  - window counter 0
- Threshold register:
  - Written only in IDLE when `cfg_we`=1.
  - `cfg_we` in any other state leaves the threshold unchanged and pulses `cfg_rej` next cycle.
  - A threshold of 0 is treated as 1.
- IDLE:
  - `arm`=1 → ARMED, `count` cleared.
  - `aes_done` ignored.
- ARMED:
  - `arm`=0 → IDLE, `count` cleared. Disarm has priority over a simultaneous `aes_done`.
  - Otherwise `aes_done`=1 increments `count` (CNT_W-bit, no wrap possible since it fires at or before threshold).
  - When incremented value == effective threshold → FIRE, window counter loaded with `WIN_LEN`.
- FIRE:
  - `trigger`=1 throughout.
  - `aes_done` ignored; `count` held at threshold.
  - Window counter decrements each cycle; at 1 → exit.
  - `arm`=0 during FIRE does not truncate the window.
- Exit from FIRE: see Configuration.
- PARK:
  - `trigger`=0, `count` held.
  - Stays until `arm`=0 → IDLE (count cleared).
- `rst` mid-operation (any state, including mid-window) returns all registers to reset values on that edge; `trigger` low the following cycle.

## Timing
- `state`, `count`, `trigger`, `cfg_rej` are all registered.
- `aes_done` sampled at edge N → `count` updates at N.
- If that sample reaches threshold: `state`=FIRE and `trigger`=1 from edge N, visible in cycle N+1.
- `trigger` high for exactly `WIN_LEN` consecutive cycles.
- `arm` rising sampled at edge N → ARMED from N; an `aes_done` at the same edge is not counted.
- `cfg_we` in IDLE at edge N → new threshold effective from N.

## Configuration
- `TSC_AUTO_REARM_EN` defined: on FIRE exit, `count` cleared.
  - `arm`=1 → ARMED, re-counts from 0.
  - `arm`=0 → IDLE.
  - PARK unreachable.
- Not defined: FIRE exit → PARK unconditionally. A new trigger requires `arm` low then high.

## Test plan
- Reset defaults, THRESH_RST=16, WIN_LEN=4: `arm`=1, 16 `aes_done` pulses spaced 3 cycles.
  - `count` 1..16.
  - `trigger` high 4 cycles starting the cycle after the 16th pulse.
  - Then PARK (no macro) or ARMED with `count`=0 (macro).
- Config gating:
  - `cfg_thresh`=3 with `cfg_we` in IDLE, then arm + 3 pulses → fire after 3rd.
  - `cfg_we` in ARMED with value 9 → `cfg_rej` pulse, threshold stays 3.
- Threshold 0 written: arm, one `aes_done` → FIRE on that pulse.
- Simultaneous events:
  - `arm` falls on the same edge as the 3rd (final) pulse → IDLE, `count`=0, no trigger.
  - `aes_done` on the same edge as `arm` rising → `count` stays 0.
- `rst` asserted in 2nd cycle of trigger window → `trigger` 0, `state` IDLE, `count` 0, threshold back to 16.
- No macro: after fire, `arm` held high plus 20 pulses → stays PARK, `trigger` 0. Then `arm` low → IDLE. Then `arm` high → ARMED with `count` 0.
